// File: rtl/sgpr_wr_port_arbiter.sv
// Registered one-hot write-port arbiter for the scalar register file: starved ports, then LSU, then round-robin.
// Latency: request sampled at edge t is granted during cycle t+1; at most one grant per cycle, no idle gaps.
module sgpr_wr_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  fu_wr_req,
  output logic [15:0] rfa_select_fu,
  output logic        rfa_grant_valid,
  output logic        rfa_starve_pending
);

  // Non-LSU ports are handled by "position" 0..8, where position 8 is the SALU (port 9).
  localparam int NP = 9;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [31:0]      LIMIT   = STARVE_LIMIT;

  logic [3:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] wait_cnt_q [NP];
  logic [CNT_W-1:0] wait_cnt_d [NP];
  logic [15:0]      rfa_select_fu_d;
  logic             rfa_starve_pending_d;

  logic [NP-1:0] pos_req;
  logic [NP-1:0] starved;
  logic [3:0]    ptr_pos;
  logic [4:0]    pick_s;
  logic [4:0]    pick_r;
  logic          gpos_vld;
  logic [3:0]    gpos;
  logic [3:0]    gport;
  logic [3:0]    next_pos;

  // Returns {found, position} of the first set bit at or after start, wrapping circularly.
  function automatic logic [4:0] rr_pick(input logic [NP-1:0] vec, input logic [3:0] start);
    logic [4:0] res;
    logic [4:0] sum;
    logic [3:0] idx;
    res = '0;
    for (int i = NP - 1; i >= 0; i--) begin
      sum = {1'b0, start} + 5'(i);
      if (sum >= 5'(NP)) sum = sum - 5'(NP);
      idx = sum[3:0];
      if (vec[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    pos_req  = {fu_wr_req[9], fu_wr_req[7:0]};
    ptr_pos  = (rr_ptr_q == 4'd9) ? 4'd8 : rr_ptr_q;
    for (int k = 0; k < NP; k++) begin
      starved[k] = pos_req[k] && (32'(wait_cnt_q[k]) >= LIMIT);
    end
    pick_s = rr_pick(starved, ptr_pos);
    pick_r = rr_pick(pos_req, ptr_pos);

    rfa_select_fu_d = '0;
    rr_ptr_d        = rr_ptr_q;
    gpos_vld        = 1'b0;
    gpos            = '0;
    gport           = '0;
    next_pos        = '0;

    if (pick_s[4]) begin
      gpos_vld = 1'b1;
      gpos     = pick_s[3:0];
    end else if (fu_wr_req[8]) begin
      rfa_select_fu_d[8] = 1'b1;
    end else if (pick_r[4]) begin
      gpos_vld = 1'b1;
      gpos     = pick_r[3:0];
    end

    if (gpos_vld) begin
      gport    = (gpos == 4'd8) ? 4'd9 : gpos;
      rfa_select_fu_d[gport] = 1'b1;
      next_pos = (gpos == 4'd8) ? 4'd0 : gpos + 4'd1;
      rr_ptr_d = (next_pos == 4'd8) ? 4'd9 : next_pos;
    end

    rfa_starve_pending_d = 1'b0;
    for (int k = 0; k < NP; k++) begin
      if (!pos_req[k] || (gpos_vld && gpos == 4'(k))) begin
        wait_cnt_d[k] = '0;
      end else if (wait_cnt_q[k] != CNT_MAX) begin
        wait_cnt_d[k] = wait_cnt_q[k] + 1'b1;
      end else begin
        wait_cnt_d[k] = wait_cnt_q[k];
      end
      // Pending tracks the counters as they will be registered, so it aligns with wait_cnt_q.
      if (32'(wait_cnt_d[k]) >= LIMIT) rfa_starve_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q           <= '0;
      rfa_select_fu      <= '0;
      rfa_grant_valid    <= 1'b0;
      rfa_starve_pending <= 1'b0;
      for (int k = 0; k < NP; k++) wait_cnt_q[k] <= '0;
    end else begin
      rr_ptr_q           <= rr_ptr_d;
      rfa_select_fu      <= rfa_select_fu_d;
      rfa_grant_valid    <= |rfa_select_fu_d;
      rfa_starve_pending <= rfa_starve_pending_d;
      for (int k = 0; k < NP; k++) wait_cnt_q[k] <= wait_cnt_d[k];
    end
  end

endmodule

// File: tb/tb_sgpr_wr_port_arbiter.sv
// Directed bench for sgpr_wr_port_arbiter: vector table plus reset, async-reset and saturation sequences.
module tb_sgpr_wr_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  req = '0;
  logic [15:0] sel;
  logic        vld;
  logic        pend;
  logic [9:0]  req2 = '0;
  logic [15:0] sel2;
  logic        vld2;
  logic        pend2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sgpr_wr_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .fu_wr_req(req),
    .rfa_select_fu(sel), .rfa_grant_valid(vld), .rfa_starve_pending(pend)
  );

  sgpr_wr_port_arbiter #(.STARVE_LIMIT(7), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .fu_wr_req(req2),
    .rfa_select_fu(sel2), .rfa_grant_valid(vld2), .rfa_starve_pending(pend2)
  );

  typedef struct {
    logic        rst_before;
    logic [9:0]  req;
    logic [15:0] sel;
    logic        pend;
  } vec_t;

  vec_t vt [18];
  int   nv = 0;

  task automatic add_vec(input logic rb, input logic [9:0] r, input logic [15:0] s, input logic p);
    vt[nv].rst_before = rb;
    vt[nv].req        = r;
    vt[nv].sel        = s;
    vt[nv].pend       = p;
    nv++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    req  = '0;
    req2 = '0;
    rst  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] sat_exp [$];
    logic        found;

    // Idle after a clean release.
    add_vec(1, 10'h000, 16'h0000, 0);
    add_vec(0, 10'h000, 16'h0000, 0);
    // Round-robin over simd0-3 and salu.
    add_vec(1, 10'h20F, 16'h0001, 0);
    add_vec(0, 10'h20F, 16'h0002, 0);
    add_vec(0, 10'h20F, 16'h0004, 0);
    add_vec(0, 10'h20F, 16'h0008, 1);
    add_vec(0, 10'h20F, 16'h0200, 1);
    add_vec(0, 10'h20F, 16'h0001, 1);
    // LSU priority over an unstarved port.
    add_vec(1, 10'h101, 16'h0100, 0);
    add_vec(0, 10'h101, 16'h0100, 0);
    add_vec(0, 10'h001, 16'h0001, 0);
    add_vec(0, 10'h000, 16'h0000, 0);
    // Starved simf2 pre-empts a continuous LSU stream.
    add_vec(1, 10'h140, 16'h0100, 0);
    add_vec(0, 10'h140, 16'h0100, 0);
    add_vec(0, 10'h140, 16'h0100, 0);
    add_vec(0, 10'h140, 16'h0100, 1);
    add_vec(0, 10'h140, 16'h0040, 0);
    add_vec(0, 10'h140, 16'h0100, 0);

    // Reset held with every request asserted: outputs must stay clear across edges.
    rst = 1'b0;
    req = 10'h3FF;
    repeat (3) @(posedge clk);
    #1;
    check("reset_sel", 32'(sel), 32'h0);
    check("reset_vld", 32'(vld), 32'h0);
    check("reset_pend", 32'(pend), 32'h0);

    for (int i = 0; i < nv; i++) begin
      if (vt[i].rst_before) do_reset();
      req = vt[i].req;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_sel", i), 32'(sel), 32'(vt[i].sel));
      check($sformatf("vec%0d_vld", i), 32'(vld), 32'(vt[i].sel != 16'h0));
      check($sformatf("vec%0d_pend", i), 32'(pend), 32'(vt[i].pend));
    end

    // Asynchronous reset while simd2 holds the grant.
    do_reset();
    req   = 10'h20F;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(posedge clk);
      #1;
      if (sel == 16'h0004) found = 1'b1;
    end
    check("async_saw_grant4", 32'(found), 32'h1);
    #4 rst = 1'b0;
    #1;
    check("async_sel_drop", 32'(sel), 32'h0);
    check("async_vld_drop", 32'(vld), 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("async_first_grant", 32'(sel), 32'h0001);
    @(posedge clk);
    #1;
    check("async_second_grant", 32'(sel), 32'h0002);

    // Counter saturation: LSU plus simd1 and simf1 held, limit equal to the counter maximum.
    do_reset();
    repeat (7) sat_exp.push_back(16'h0100);
    sat_exp.push_back(16'h0002);
    sat_exp.push_back(16'h0020);
    repeat (6) sat_exp.push_back(16'h0100);
    sat_exp.push_back(16'h0002);
    sat_exp.push_back(16'h0020);
    req2 = 10'h122;
    for (int i = 0; i < sat_exp.size(); i++) begin
      @(posedge clk);
      #1;
      check($sformatf("sat%0d_sel", i), 32'(sel2), 32'(sat_exp[i]));
      check($sformatf("sat%0d_onehot", i), 32'($onehot0(sel2)), 32'h1);
    end
    req2 = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sgpr_wr_port_arbiter.md
# sgpr_wr_port_arbiter

Registered write-port arbiter for the scalar register file. It collects write requests from the eight SIMD/SIMF functional units, the LSU and the SALU, and produces the one-hot `rfa_select_fu` vector consumed by the SGPR write-port mux. The LSU normally has fixed priority. The other nine requesters share round-robin service, and a per-port starvation counter lets a long-waiting requester pre-empt the LSU.

## Interface
Parameters:
- STARVE_LIMIT, 4: wait cycles after which a non-LSU requester is marked starved (1..7).
- CNT_W, 3: width of each per-port wait counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-low (asserted at 0).
- fu_wr_req  input  10  per-port write request, held level:
  - bits 0-3: simd0-3
  - bits 4-7: simf0-3
  - bit 8: lsu
  - bit 9: salu
- rfa_select_fu  output  16  registered one-hot grant; bit i selects port i; bits 15:10 are always 0.
- rfa_grant_valid  output  1  registered; equals |rfa_select_fu.
- rfa_starve_pending  output  1  registered; high while any non-LSU wait counter is >= STARVE_LIMIT.

## Operation
- Request semantics:
  - Each cycle in which a port's grant bit is high counts as exactly one write by that port.
  - A requester with no further write deasserts its request in the same cycle its grant bit is visible.
  - A request still high in a granted cycle is a new request.
- State:
  - rr_ptr[3:0] holds the highest-priority non-LSU port index, range {0..7, 9}; value 8 is never stored.
  - One wait_cnt[CNT_W-1:0] per non-LSU port (9 counters).
  - Output registers.
- Starved set: non-LSU ports with req=1 and wait_cnt >= STARVE_LIMIT.
- Arbitration, combinational from the current req and state, evaluated in this order:
  - 1. If the starved set is non-empty: grant the first starved port at or after rr_ptr, in circular order 0..7,9.
  - 2. Else if req[8]: grant the LSU.
  - 3. Else: grant the first requesting non-LSU port at or after rr_ptr, in circular order.
  - 4. Else: no grant.
- rr_ptr update:
  - On a non-LSU grant to port p: rr_ptr becomes the successor of p in the order 0..7,9,0.
  - On an LSU grant or no grant: rr_ptr is unchanged.
- wait_cnt update, per non-LSU port:
  - Becomes 0 if req=0 or the port is granted this cycle.
  - Else increments, saturating at 2^CNT_W-1.
- Counters update in the same cycle the grant decision is registered.
- The arbiter issues at most one grant per cycle; there is no idle cycle between grants.
- Only the LSU can issue multi-dword writes; the arbiter treats every grant as a single cycle regardless of width.

## Timing
- Latency: request sampled at edge t produces the grant on rfa_select_fu during cycle t+1. The granted FU drives wr_en/addr/data in cycle t+1, aligned with the mux select.
- Back-to-back: a requester holding req high can be granted on consecutive cycles only if no other port outranks it. Round-robin guarantees other non-LSU requesters are served before it repeats.
- Worst-case non-LSU wait under continuous LSU traffic: STARVE_LIMIT+1 cycles to starved status, then at most 8 further starved peers.
- Reset (rst=0, asynchronous):
  - rfa_select_fu=0, rfa_grant_valid=0, rfa_starve_pending=0.
  - rr_ptr=0, all wait_cnt=0.
- First grant: the earliest grant is in the cycle after the first rising edge following reset deassertion on which a request is sampled.
- Reset mid-grant: the output drops to 0 immediately, without waiting for the clock edge. Any pending requests are re-arbitrated from rr_ptr=0 after release.
- Simultaneous events:
  - Starved ports beat the LSU.
  - The LSU beats unstarved ports.
  - Ties among starved or among unstarved ports are resolved by rr_ptr.
- Invariants:
  - rfa_select_fu is always zero or one-hot.
  - A bit is never set for a port whose request was low at the sampling edge.

## Test plan
- Reset/idle: hold rst=0 with fu_wr_req=10'h3FF -> all outputs 0. Release rst with requests at 0 -> outputs stay 0.
- Round-robin: fu_wr_req=10'h20F held for 6 cycles -> grants 0x0001, 0x0002, 0x0004, 0x0008, 0x0200, 0x0001 on consecutive cycles.
- LSU priority: fu_wr_req=10'h101 for 2 cycles, then 10'h001 -> two cycles of 0x0100, then 0x0001. Wait_cnt[0]=2 at that point, so no starvation occurs.
- Starvation pre-empt (STARVE_LIMIT=4): LSU held continuously plus simf2 (bit 6) asserted -> 0x0100 for 4 cycles, rfa_starve_pending=1, then 0x0040, then 0x0100 again with rfa_starve_pending=0.
- Counter saturation: CNT_W=3, STARVE_LIMIT=7, LSU and two starving ports held -> counters stop at 7 without wrapping. Starved ports are served alternately by rr_ptr; the one-hot invariant holds throughout.
- Asynchronous reset mid-stream: drive rst low half a cycle after grant 0x0004 appears -> rfa_select_fu=0 before the next clk edge. After release with the same requests, the first grant follows rr_ptr=0 order.
